// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch port: req/gnt issue plus rvalid response.
// master = fetch sequencer, slave = instruction memory.
interface pc_fetch_sequencer_if #(
  parameter int n = 32
);
  logic         imem_req;
  logic [n-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC register and single-outstanding fetch sequencer.
// Applies stall, branch/jump and trap redirects; drops stale responses.
module pc_fetch_sequencer #(
  parameter int          n            = 32,
  parameter logic [n-1:0] RESET_VECTOR = '0,
  parameter logic [n-1:0] TRAP_VECTOR  = n'(32'h100)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [n-1:0]          redirect_pc,
  input  logic                  trap,
  pc_fetch_sequencer_if.master  imem,
  output logic [n-1:0]          pc,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [n-1:0]          instr_pc,
  output logic                  misaligned
);

  typedef enum logic [2:0] {
    BOOT,
    HOLD,
    ISSUE,
    WAIT,
    DROP
  } state_e;

  state_e       state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [n-1:0] instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         misaligned_q, misaligned_d;

  logic         redir;
  logic         misal;
  logic [n-1:0] tgt;
  logic         req;
  state_e       after_fetch;

  // Redirect target resolution: trap wins, misaligned targets trap.
  always_comb begin
    redir        = trap | redirect_valid;
    misal        = redirect_pc[1:0] != 2'b00;
    tgt          = (trap || misal) ? TRAP_VECTOR : redirect_pc;
    misaligned_d = redirect_valid & ~trap & misal;
    after_fetch  = stall ? HOLD : ISSUE;
  end

  // Next-state, PC update and fetch-port control.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = 1'b0;
    req           = 1'b0;
    unique case (state_q)
      BOOT, HOLD: begin
        state_d = after_fetch;
        if (redir) pc_d = tgt;
      end
      ISSUE: begin
        req = 1'b1;
        if (imem.imem_gnt) begin
          fetch_pc_d = pc_q;
          if (redir) begin
            pc_d    = tgt;
            state_d = DROP;
          end else begin
            pc_d    = pc_q + n'(4);
            state_d = WAIT;
          end
        end else if (redir) begin
          pc_d = tgt;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          state_d = after_fetch;
          if (redir) begin
            pc_d = tgt;
          end else begin
            instr_d       = imem.imem_rdata;
            instr_pc_d    = fetch_pc_q;
            instr_valid_d = 1'b1;
          end
        end else if (redir) begin
          pc_d    = tgt;
          state_d = DROP;
        end
      end
      DROP: begin
        if (redir) pc_d = tgt;
        if (imem.imem_rvalid) state_d = after_fetch;
      end
      default: state_d = BOOT;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_pc_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios, then random
// traffic checked against a transaction-level fetch model.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [31:0] pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned;

  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.n(32)) bus ();

  pc_fetch_sequencer #(
    .n            (32),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap           (trap),
    .imem           (bus),
    .pc             (pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misaligned     (misaligned)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: expected PC, whether a request should be up,
  // and the single outstanding fetch (address, stale flag).
  logic [31:0] m_pc;
  logic        m_req;
  logic        m_out;
  logic        m_stale;
  logic [31:0] m_oaddr;
  logic        m_iv;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_mis;
  int          rcnt;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    trap            = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
  endtask

  task automatic model_reset();
    m_pc    = RV;
    m_req   = 1'b0;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_oaddr = '0;
    m_iv    = 1'b0;
    m_instr = '0;
    m_ipc   = '0;
    m_mis   = 1'b0;
    rcnt    = 0;
  endtask

  // One clock edge of the fetch protocol, expressed as transactions.
  task automatic model_edge();
    logic        redir;
    logic        mis;
    logic        granted;
    logic        resp;
    logic        nreq;
    logic [31:0] t;
    redir   = trap | redirect_valid;
    mis     = redirect_pc[1:0] != 2'b00;
    t       = (trap || mis) ? TV : redirect_pc;
    granted = m_req && bus.imem_gnt;
    resp    = m_out && bus.imem_rvalid;
    nreq    = (m_req && !bus.imem_gnt) ? 1'b1 : !stall;
    m_mis   = redirect_valid && !trap && mis;
    m_iv    = resp && !m_stale && !redir;
    if (m_iv) begin
      m_instr = bus.imem_rdata;
      m_ipc   = m_oaddr;
    end
    if (resp) m_out = 1'b0;
    else if (m_out && redir) m_stale = 1'b1;
    if (granted) begin
      m_out   = 1'b1;
      m_oaddr = m_pc;
      m_stale = redir;
    end
    if (redir) m_pc = t;
    else if (granted) m_pc = m_pc + 32'd4;
    m_req = !m_out && nreq;
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) chk("addr", bus.imem_addr, m_pc);
    chk("iv", 32'(instr_valid), 32'(m_iv));
    if (m_iv) begin
      chk("instr", instr, m_instr);
      chk("ipc", instr_pc, m_ipc);
    end
    chk("mis", 32'(misaligned), 32'(m_mis));
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic g;
    int   r;
    idle();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    resetn = 1'b1;

    // first fetch straight out of reset
    step();
    chk("t1_addr0", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    chk("t1_pc4", pc, 32'h4);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0050_0093;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t1_iv", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_ipc", instr_pc, 32'h0);
    chk("t1_addr4", bus.imem_addr, 32'h4);

    // stall held in HOLD
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h00a0_0113;
    stall           = 1'b1;
    step();
    bus.imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req0", 32'(bus.imem_req), 32'd0);
      chk("t2_pc", pc, 32'h8);
    end
    stall = 1'b0;
    step();
    chk("t2_req1", 32'(bus.imem_req), 32'd1);

    // redirect while waiting, response dropped
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt   = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid  = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hdead_beef;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t3_iv", 32'(instr_valid), 32'd0);
    chk("t3_addr", bus.imem_addr, 32'h40);

    // trap priority, misaligned target
    trap           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    trap = 1'b0;
    chk("t4_trap_pc", pc, 32'h100);
    chk("t4_nomis", 32'(misaligned), 32'd0);
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("t4_mis_pc", pc, 32'h100);
    chk("t4_mis1", 32'(misaligned), 32'd1);
    step();
    chk("t4_mis0", 32'(misaligned), 32'd0);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("t6_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    chk("t6_pc0", pc, 32'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0013;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t6_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("t6_addr0", bus.imem_addr, 32'h0);

    // reset mid-WAIT, late response ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    redirect_valid = 1'b0;
    bus.imem_gnt   = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t5_pc", pc, 32'h0);
    chk("t5_iv", 32'(instr_valid), 32'd0);
    chk("t5_ipc", instr_pc, 32'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1234_5678;
    step();
    resetn = 1'b1;
    step();
    bus.imem_rvalid = 1'b0;
    chk("t5_late_iv", 32'(instr_valid), 32'd0);
    chk("t5_addr0", bus.imem_addr, 32'h0);

    // random traffic against the model
    for (int k = 0; k < 800; k++) begin
      stall          = ($urandom % 4) == 0;
      redirect_valid = ($urandom % 8) == 0;
      trap           = ($urandom % 24) == 0;
      r = int'($urandom % 8);
      if (r == 0) redirect_pc = 32'hFFFF_FFF8 + ($urandom % 2) * 4;
      else if (r == 1) redirect_pc = {$urandom, 2'b00} | 32'h2;
      else redirect_pc = ($urandom % 256) << 2;
      bus.imem_gnt = m_req && (($urandom % 2) == 0);
      if (m_out && rcnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem(m_oaddr);
      end else if (!m_out && ($urandom % 6) == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = $urandom;
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
      g = m_req && bus.imem_gnt;
      step();
      if (g) rcnt = int'($urandom % 3);
      else if (m_out && rcnt > 0) rcnt--;
      if (m_iv) chk("rnd_mem", instr, mem(instr_pc));
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
